// File: rtl/spi_reg_master.sv
// Register read/write sequencer in front of spi_master: frames header + data bytes on MOSI, gathers MISO echoes.
// Optional inter-byte timeout enabled by defining SPI_REG_MASTER_TIMEOUT_EN.
module spi_reg_master #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_BYTES     = 4,
  parameter logic [7:0]  DUMMY_BYTE     = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_read,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [$clog2(DATA_BYTES+1)-1:0] cmd_len,
  input  logic [8*DATA_BYTES-1:0]         cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [8*DATA_BYTES-1:0]         rsp_rdata,
  output logic                            rsp_error,
  output logic                            mosi_stream_tvalid,
  input  logic                            mosi_stream_tready,
  output logic [7:0]                      mosi_stream_tdata,
  output logic                            mosi_stream_tlast,
  output logic                            mosi_stream_tkeep,
  output logic                            mosi_stream_tid,
  output logic                            mosi_stream_tdest,
  output logic                            mosi_stream_tuser,
  input  logic                            miso_stream_tvalid,
  output logic                            miso_stream_tready,
  input  logic [7:0]                      miso_stream_tdata,
  input  logic                            miso_stream_tlast
);

  localparam int unsigned LW = $clog2(DATA_BYTES + 1);
  localparam int unsigned CW = $clog2(DATA_BYTES + 2);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic                    r_miso_tready;
  logic                    r_mosi_tvalid;
  logic [7:0]              r_mosi_tdata;
  logic                    r_mosi_tlast;
  logic                    r_is_read;
  logic [CW-1:0]           r_n;
  logic [CW-1:0]           r_tx_idx;
  logic [CW-1:0]           r_rx_cnt;
  logic [8*DATA_BYTES-1:0] r_wdata;
  logic [8*DATA_BYTES-1:0] r_rdata;

  logic                    w_cmd_hs;
  logic                    w_mosi_hs;
  logic                    w_miso_hs;
  logic                    w_rx_last;
  logic                    w_timeout;
  logic [LW-1:0]           w_len;
  logic [7:0]              w_header;
  logic                    w_unused;

  assign w_cmd_hs  = cmd_valid && r_cmd_ready;
  assign w_mosi_hs = r_mosi_tvalid && mosi_stream_tready;
  assign w_miso_hs = (r_state == XFER) && miso_stream_tvalid && r_miso_tready;
  assign w_rx_last = w_miso_hs && (r_rx_cnt == r_n - CW'(1));
  assign w_len     = (cmd_len > LW'(DATA_BYTES)) ? LW'(DATA_BYTES) : cmd_len;
  assign w_header  = {cmd_read, cmd_addr};

  assign cmd_ready          = r_cmd_ready;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_rdata          = r_rdata;
  assign mosi_stream_tvalid = r_mosi_tvalid;
  assign mosi_stream_tdata  = r_mosi_tdata;
  assign mosi_stream_tlast  = r_mosi_tlast;
  assign mosi_stream_tkeep  = 1'b1;
  assign mosi_stream_tid    = 1'b0;
  assign mosi_stream_tdest  = 1'b0;
  assign mosi_stream_tuser  = 1'b0;
  assign miso_stream_tready = r_miso_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Completion is decided by the receive count alone; the transmit side always finishes first.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_state_next = XFER;
      XFER:    if (w_rx_last || w_timeout) w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_miso_tready <= 1'b0;
      r_mosi_tvalid <= 1'b0;
      r_mosi_tdata  <= '0;
      r_mosi_tlast  <= 1'b0;
      r_is_read     <= 1'b0;
      r_n           <= '0;
      r_tx_idx      <= '0;
      r_rx_cnt      <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
    end else begin
      r_cmd_ready   <= (w_state_next == IDLE);
      r_rsp_valid   <= (w_state_next == RESP);
      r_miso_tready <= (w_state_next != RESP);
      if (w_cmd_hs) begin
        r_is_read     <= cmd_read;
        r_n           <= CW'(w_len) + CW'(1);
        r_tx_idx      <= '0;
        r_rx_cnt      <= '0;
        r_rdata       <= '0;
        // Reads shift out dummy bytes through the same path as write data.
        r_wdata       <= cmd_read ? {DATA_BYTES{DUMMY_BYTE}} : cmd_wdata;
        r_mosi_tvalid <= 1'b1;
        r_mosi_tdata  <= w_header;
        r_mosi_tlast  <= (w_len == '0);
      end else if (r_state == XFER) begin
        if (w_timeout) begin
          r_mosi_tvalid <= 1'b0;
          r_mosi_tlast  <= 1'b0;
        end else if (w_mosi_hs) begin
          if (r_mosi_tlast) begin
            r_mosi_tvalid <= 1'b0;
            r_mosi_tlast  <= 1'b0;
          end else begin
            r_mosi_tdata <= r_wdata[7:0];
            r_wdata      <= r_wdata >> 8;
            r_tx_idx     <= r_tx_idx + CW'(1);
            r_mosi_tlast <= (r_tx_idx + CW'(2) == r_n);
          end
        end
        if (w_miso_hs) begin
          r_rx_cnt <= r_rx_cnt + CW'(1);
          if (r_is_read) begin
            for (int unsigned b = 0; b < DATA_BYTES; b++) begin
              if (r_rx_cnt == CW'(b + 1)) r_rdata[8*b +: 8] <= miso_stream_tdata;
            end
          end
        end
      end
    end
  end

`ifdef SPI_REG_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_rsp_error;

  assign w_timeout = (r_state == XFER) && !w_miso_hs && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_error = r_rsp_error;
  assign w_unused  = miso_stream_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt    <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_cmd_hs) begin
      r_to_cnt    <= '0;
      r_rsp_error <= 1'b0;
    end else if (r_state == XFER) begin
      r_to_cnt <= w_miso_hs ? '0 : r_to_cnt + TW'(1);
      if (w_timeout) r_rsp_error <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign rsp_error = 1'b0;
  assign w_unused  = miso_stream_tlast ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: loopback echo sink, MOSI/response scoreboards, backpressure and reset cases.
module tb_spi_reg_master;
  localparam int unsigned DB = 4;

  typedef struct packed { logic [7:0] d; logic l; } mosi_t;
  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [6:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mosi_tvalid, mosi_tready, mosi_tlast, mosi_tkeep, mosi_tid, mosi_tdest, mosi_tuser;
  logic [7:0]  mosi_tdata;
  logic        miso_tvalid, miso_tready, miso_tlast;
  logic [7:0]  miso_tdata;

  mosi_t      exp_mosi[$];
  rsp_t       exp_rsp[$];
  logic [7:0] echo_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int tready_mode = 0;
  int echo_budget = -1;
  int last_echo_cyc = 0, rsp_rise_cyc = 0;
  logic rsp_valid_q = 1'b0;
  logic stalled = 1'b0, stall_l, m_mosi_hs, m_miso_hs;
  logic [7:0] stall_d, m_mosi_d;
  mosi_t m_e;
  rsp_t  m_r;

  spi_reg_master #(.ADDR_WIDTH(7), .DATA_BYTES(DB), .DUMMY_BYTE(8'hFF), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mosi_stream_tvalid(mosi_tvalid), .mosi_stream_tready(mosi_tready), .mosi_stream_tdata(mosi_tdata),
    .mosi_stream_tlast(mosi_tlast), .mosi_stream_tkeep(mosi_tkeep), .mosi_stream_tid(mosi_tid),
    .mosi_stream_tdest(mosi_tdest), .mosi_stream_tuser(mosi_tuser),
    .miso_stream_tvalid(miso_tvalid), .miso_stream_tready(miso_tready), .miso_stream_tdata(miso_tdata),
    .miso_stream_tlast(miso_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"},   64'(cmd_ready),   64'(1'b0));
    check({tag, "_rsp_valid"},   64'(rsp_valid),   64'(1'b0));
    check({tag, "_rsp_rdata"},   64'(rsp_rdata),   64'(32'h0));
    check({tag, "_rsp_error"},   64'(rsp_error),   64'(1'b0));
    check({tag, "_mosi_tvalid"}, 64'(mosi_tvalid), 64'(1'b0));
    check({tag, "_mosi_tdata"},  64'(mosi_tdata),  64'(8'h0));
    check({tag, "_mosi_tlast"},  64'(mosi_tlast),  64'(1'b0));
    check({tag, "_miso_tready"}, 64'(miso_tready), 64'(1'b0));
  endtask

  // Monitor + loopback sink: decide handshakes at negedge, update sink state just after posedge.
  always begin
    @(negedge clk);
    m_mosi_hs = mosi_tvalid && mosi_tready;
    m_miso_hs = miso_tvalid && miso_tready;
    m_mosi_d  = mosi_tdata;
    if (stalled && mosi_tvalid)
      check("mosi_stable", 64'({mosi_tdata, mosi_tlast}), 64'({stall_d, stall_l}));
    stalled = mosi_tvalid && !mosi_tready;
    stall_d = mosi_tdata;
    stall_l = mosi_tlast;
    if (m_mosi_hs) begin
      checks++;
      assert (exp_mosi.size() != 0) else begin
        errors++;
        $error("FAIL mosi_extra: observed byte %0h expected none", mosi_tdata);
      end
      if (exp_mosi.size() != 0) begin
        m_e = exp_mosi.pop_front();
        check("mosi_byte", 64'({mosi_tdata, mosi_tlast}), 64'({m_e.d, m_e.l}));
      end
    end
    if (rsp_valid && rsp_ready) begin
      checks++;
      assert (exp_rsp.size() != 0) else begin
        errors++;
        $error("FAIL rsp_extra: observed rdata %0h expected none", rsp_rdata);
      end
      if (exp_rsp.size() != 0) begin
        m_r = exp_rsp.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(m_r.rdata));
        check("rsp_error", 64'(rsp_error), 64'(m_r.err));
      end
    end
    if (m_miso_hs) last_echo_cyc = cyc + 1;
    if (rsp_valid && !rsp_valid_q) rsp_rise_cyc = cyc;
    rsp_valid_q = rsp_valid;
    @(posedge clk);
    #1;
    if (m_miso_hs && echo_q.size() != 0) void'(echo_q.pop_front());
    if (m_mosi_hs && echo_budget != 0) begin
      echo_q.push_back(m_mosi_d);
      if (echo_budget > 0) echo_budget--;
    end
    miso_tvalid = (echo_q.size() != 0);
    miso_tdata  = (echo_q.size() != 0) ? echo_q[0] : 8'h00;
    case (tready_mode)
      0:       mosi_tready = 1'b1;
      1:       mosi_tready = ~mosi_tready;
      default: mosi_tready = 1'b0;
    endcase
  end

  task automatic issue(input logic rd, input logic [6:0] addr, input int len,
                       input logic [31:0] wd, input logic err);
    int n;
    logic seen;
    mosi_t e;
    rsp_t r;
    n = (len > int'(DB)) ? int'(DB) : len;
    e.d = {rd, addr};
    e.l = (n == 0);
    exp_mosi.push_back(e);
    for (int j = 1; j <= n; j++) begin
      e.d = rd ? 8'hFF : wd[8*(j-1) +: 8];
      e.l = (j == n);
      exp_mosi.push_back(e);
    end
    r.rdata = '0;
    r.err   = err;
    if (rd && !err)
      for (int j = 0; j < n; j++) r.rdata[8*j +: 8] = 8'hFF;
    exp_rsp.push_back(r);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_len   = 3'(len);
    cmd_wdata = wd;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = cmd_ready;
    end
    check("cmd_accept", 64'(seen), 64'(1'b1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_rsp.size() != 0; i++) @(negedge clk);
    check("done_rsp_pending",  64'(exp_rsp.size()),  64'(0));
    check("done_mosi_pending", 64'(exp_mosi.size()), 64'(0));
  endtask

  task automatic run_cmd(input logic rd, input logic [6:0] addr, input int len,
                         input logic [31:0] wd, input logic err);
    issue(rd, addr, len, wd, err);
    wait_done();
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; mosi_tready = 1'b1;
    miso_tvalid = 1'b0; miso_tdata = '0; miso_tlast = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1'b1));

    run_cmd(1'b0, 7'h12, 1, 32'h000000A5, 1'b0);
    run_cmd(1'b1, 7'h05, 2, 32'h0, 1'b0);
    run_cmd(1'b1, 7'h7F, 0, 32'h0, 1'b0);
    run_cmd(1'b0, 7'h33, 7, 32'h44332211, 1'b0);
    run_cmd(1'b1, 7'h41, 4, 32'h0, 1'b0);

    tready_mode = 1;
    rsp_ready = 1'b0;
    issue(1'b0, 7'h2C, 4, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      @(negedge clk);
      check("bp_cmd_ready_busy", 64'(cmd_ready), 64'(1'b0));
    end
    check("bp_rsp_valid_seen", 64'(rsp_valid), 64'(1'b1));
    repeat (10) begin
      @(negedge clk);
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'(1'b1));
      check("bp_cmd_ready_low",  64'(cmd_ready), 64'(1'b0));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    tready_mode = 0;
    wait_done();

`ifdef SPI_REG_MASTER_TIMEOUT_EN
    echo_budget = 1;
    issue(1'b1, 7'h05, 2, 32'h0, 1'b1);
    for (int i = 0; i < 300 && !rsp_valid; i++) @(negedge clk);
    check("to_rsp_valid_seen", 64'(rsp_valid), 64'(1'b1));
    @(negedge clk);
    check("to_latency", 64'(rsp_rise_cyc - last_echo_cyc), 64'(16));
    wait_done();
    echo_budget = -1;
    run_cmd(1'b1, 7'h06, 3, 32'h0, 1'b0);
`endif

    tready_mode = 2;
    repeat (2) @(posedge clk);
    issue(1'b1, 7'h22, 4, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    exp_mosi.delete();
    exp_rsp.delete();
    echo_q.delete();
    miso_tvalid = 1'b0;
    tready_mode = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 check("cmd_ready_after_mid_reset", 64'(cmd_ready), 64'(1'b1));
    repeat (5) begin
      @(negedge clk);
      check("no_rsp_after_reset", 64'(rsp_valid), 64'(1'b0));
    end
    run_cmd(1'b0, 7'h0A, 2, 32'h0000BEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
